// File: rtl/ps2_pkg.sv
// Shared PS/2 frame layout constants and receiver FSM state type.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_START      = 0;
  localparam int unsigned PS2_DATA_LSB   = 1;
  localparam int unsigned PS2_DATA_MSB   = 8;
  localparam int unsigned PS2_PARITY     = 9;
  localparam int unsigned PS2_STOP       = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ps2_state_e;

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 pin synchronizers, ps2_clk glitch filter and registered falling-edge strobe.
module ps2_sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_fall,
  output logic o_data
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   r_filt_d;
  logic                   r_fall;
  logic                   w_clk_s;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];

  // Sync flops reset high so reset release never looks like a falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync[0]  <= i_ps2_clk;
      r_data_sync[0] <= i_ps2_data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_clk_sync[i]  <= r_clk_sync[i-1];
        r_data_sync[i] <= r_data_sync[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fall   <= 1'b0;
    end else begin
      if (w_clk_s != r_filt) begin
        if (r_cnt == CNT_LAST) begin
          r_filt <= w_clk_s;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
      r_filt_d <= r_filt;
      r_fall   <= r_filt_d & ~r_filt;
    end
  end

  assign o_fall = r_fall;
  assign o_data = r_data_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 receive front end: shifts in one 11-bit frame and strobes it downstream.
// Optional idle abort inside a frame is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ps2_clk,
  input  logic                      ps2_data,
  output logic [PS2_FRAME_BITS-1:0] frame,
  output logic                      frame_valid,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ps2_frame_rx: TIMEOUT_CYCLES must be at least 2");
  end

  logic                      w_fall;
  logic                      w_data;
  ps2_state_e                r_state;
  logic [3:0]                r_bitcnt;
  logic [PS2_FRAME_BITS-1:0] r_shift;
  logic [PS2_FRAME_BITS-1:0] r_frame;
  logic                      r_valid;
  logic                      r_busy;
  logic [PS2_FRAME_BITS-1:0] w_shift_next;

  ps2_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync_filter (
    .clk        (clk),
    .reset      (reset),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_fall     (w_fall),
    .o_data     (w_data)
  );

  assign w_shift_next = {w_data, r_shift[PS2_FRAME_BITS-1:1]};

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES - 1);

  logic [IW-1:0] r_idle;
  logic [IW-1:0] w_idle_next;
  logic          r_tmo;

  assign w_idle_next = (r_idle == IDLE_LIMIT) ? r_idle : r_idle + 1'b1;
  assign timeout_err = r_tmo;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_frame  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      r_idle   <= '0;
      r_tmo    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      r_tmo   <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
`ifdef PS2_RX_TIMEOUT_EN
          r_idle <= '0;
`endif
          if (w_fall) begin
            r_shift  <= w_shift_next;
            r_bitcnt <= 4'd1;
            r_busy   <= 1'b1;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // A fall in the same cycle as the idle limit takes priority over the abort
          if (w_fall) begin
`ifdef PS2_RX_TIMEOUT_EN
            r_idle  <= '0;
`endif
            r_shift <= w_shift_next;
            if (r_bitcnt == LAST_BIT) begin
              r_frame  <= w_shift_next;
              r_valid  <= 1'b1;
              r_bitcnt <= '0;
              r_busy   <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
`ifdef PS2_RX_TIMEOUT_EN
          else if (w_idle_next == IDLE_LIMIT) begin
            r_tmo    <= 1'b1;
            r_idle   <= '0;
            r_bitcnt <= '0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_idle <= w_idle_next;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign frame       = r_frame;
  assign frame_valid = r_valid;
  assign busy        = r_busy;

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

- PS/2 keyboard receive front end.
- Brings the asynchronous `ps2_clk`/`ps2_data` pins into the system clock domain, glitch-filters the PS/2 clock and shifts in one 11-bit frame (start, 8 data LSB-first, parity, stop).
- Presents the frame to the downstream parity/framing checker with a one-cycle valid strobe.
- Sits between the keyboard pins and the parity checker; checks nothing itself.

## Interface

Parameters:
- `SYNC_STAGES`, 2: synchronizer flops on each PS/2 pin.
- `FILTER_LEN`, 4: consecutive cycles a new `ps2_clk` level must persist before it is accepted.
- `TIMEOUT_CYCLES`, 50000: idle cycles inside a frame before abort (1 ms at 50 MHz).

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `ps2_clk` in 1: raw keyboard clock pin, asynchronous, idle high.
- `ps2_data` in 1: raw keyboard data pin, asynchronous, idle high.
- `frame` out 11: last complete frame. Bit 0 = start, [8:1] = data, [9] = parity, [10] = stop.
- `frame_valid` out 1: one-cycle pulse when `frame` is updated.
- `busy` out 1: high while a frame is partially received.
- `timeout_err` out 1: one-cycle pulse when a partial frame is aborted.

## Operation

- **Synchronizers**
  - Each pin passes through `SYNC_STAGES` flops.
  - All synchronizer flops reset to 1, so no false edge occurs at reset release.
- **Clock filter**
  - Filtered clock resets to 1.
  - It takes the synchronized `ps2_clk` value only after that value has differed from the filtered level for `FILTER_LEN` consecutive cycles. Any shorter deviation clears the filter counter.
  - `fall` is high for one cycle when the filtered clock goes 1→0.
- **Sampling:** on a `fall` cycle, the synchronized `ps2_data` is the sampled bit.
- **FSM states**
  - IDLE: `busy` = 0, bit counter = 0. On `fall`, shift the bit in, set the counter to 1 and go to SHIFT. Any falling edge is accepted as bit 0; start-bit checking is the downstream checker's job.
  - SHIFT: `busy` = 1. On `fall`, shift the bit in and increment the counter. On the 11th bit, register the completed shift value into `frame`, pulse `frame_valid` and go to IDLE.
- **Shift order:** right shift, new bit enters at bit 10. After 11 bits, the first received bit is at bit 0.
- **Frame hold:** `frame` holds its value until the next complete frame. Partial frames never touch it.
- **Reset values:** `frame` = 11'h000, `frame_valid` = 0, `busy` = 0, `timeout_err` = 0. FSM in IDLE, counters 0.
- **Reset mid-frame:** the partial frame is discarded, with no `frame_valid` and no `timeout_err`.

## Timing

- **Pin to `fall`:** `SYNC_STAGES` + `FILTER_LEN` + 1 cycles after a clean pin transition.
- **`frame_valid`:** high in the cycle after the `fall` cycle of bit 11. `frame` is valid in the same cycle and after.
- **Back-to-back frames:** supported; the next start edge may arrive any cycle after bit 11.
- **Timeout:** in SHIFT, the idle counter clears on every `fall`. When it reaches `TIMEOUT_CYCLES`−1 without a `fall`:
  - `timeout_err` pulses one cycle,
  - bit counter clears,
  - FSM goes to IDLE,
  - `frame` is unchanged.
- **`fall` and timeout in the same cycle:** `fall` wins. The bit is shifted and the counter clears.
- **Idle counter width:** clog2(`TIMEOUT_CYCLES`); saturates, never wraps.

## Configuration

- `PS2_RX_TIMEOUT_EN` defined: idle counter and abort logic present, as above.
- Not defined: no idle counter; a stalled partial frame waits indefinitely. `timeout_err` is still a port, tied 0.

## Structure

- Shared package `ps2_pkg`:
  - `PS2_FRAME_BITS` = 11,
  - frame bit-index constants (`PS2_START`, `PS2_PARITY`, `PS2_STOP`),
  - FSM state typedef (IDLE, SHIFT).
- The parity checker reuses the index constants.
- One sub-module, `ps2_sync_filter`: pin synchronizer, clock glitch filter and `fall` detector. Instantiated once; it also carries `ps2_data` through the synchronizer only.

## Test plan

Bench uses `TIMEOUT_CYCLES`=100 and PS/2 bit period ≥ 40 cycles.
- Scan code 0x1C sent (start 0, parity 0, stop 1) → one `frame_valid` pulse, `frame` = 11'h438, `busy` 0 afterwards.
- 0xF0 then 0x1C back-to-back → `frame` = 11'h7E0, then 11'h438, exactly two pulses.
- 2-cycle low glitch on `ps2_clk` in IDLE and mid-frame (`FILTER_LEN`=4) → no bit shifted. Subsequent 0x1C frame still yields 11'h438.
- 5 bits then silence, with `PS2_RX_TIMEOUT_EN` → `timeout_err` pulse exactly 100 cycles after the 5th `fall`, `busy` 0, `frame` unchanged; next 0x1C frame yields 11'h438. Without the macro → no pulse, `busy` stays 1.
- `reset` for one cycle after 6 bits → `busy` 0, `frame` 11'h000, no pulses; next frame correct.
- Bad start bit (first bit 1, data 0x1C) → frame captured as 11'h439 with one `frame_valid`; rejection is left downstream.
